// File: rtl/riscv_ctrl_pkg.sv
// Shared control-unit types: FSM states, RV32I opcodes, ALU control and ALU-op codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRead,
        StMemWb,
        StMemWrite,
        StExecR,
        StExecI,
        StAluWb,
        StJal,
        StBeq
    } state_e;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b101;

    // alu_op selects a forced add/sub or a funct3-driven decode.
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU decoder: maps alu_op/funct3/funct7b5 to the ALU control code.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op_b5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (alu_op)
            ALU_OP_SUB: ALUControl = ALU_SUB;
            ALU_OP_FUNCT: begin
                case (funct3)
                    // op_b5 separates R-type from addi, which has no sub form.
                    3'b000:  ALUControl = (op_b5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_ADD;
                endcase
            end
            default: ALUControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I main control: Moore sequencing FSM plus ALU decoder and beq resolution.
module multicycle_control_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter bit TRACE = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       zero,
    output logic       pc_write,
    output logic       adr_src,
    output logic       mem_write,
    output logic       ir_write,
    output logic [1:0] result_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] imm_src,
    output logic       reg_write,
    output logic [2:0] ALUControl,
    output logic       illegal_op
);

    state_e     state_q, state_d;
    logic       op_legal;
    logic [1:0] alu_op;
    logic [2:0] alu_ctl;

    // Transition tracing is done by the bench; the parameter has no hardware effect.
    if (TRACE) begin : g_trace
    end

    assign op_legal = op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ, OP_JAL};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = StFetch;
        case (state_q)
            StFetch: state_d = StDecode;
            StDecode: begin
                case (op)
                    OP_LW, OP_SW: state_d = StMemAdr;
                    OP_R:         state_d = StExecR;
                    OP_I:         state_d = StExecI;
                    OP_JAL:       state_d = StJal;
                    OP_BEQ:       state_d = StBeq;
                    default:      state_d = StFetch;
                endcase
            end
            StMemAdr:   state_d = (op == OP_SW) ? StMemWrite : StMemRead;
            StMemRead:  state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWrite: state_d = StFetch;
            StExecR:    state_d = StAluWb;
            StExecI:    state_d = StAluWb;
            StAluWb:    state_d = StFetch;
            StJal:      state_d = StAluWb;
            StBeq:      state_d = StFetch;
            default:    state_d = StFetch;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op_b5      (op[5]),
        .ALUControl (alu_ctl)
    );

    always_comb begin
        pc_write   = 1'b0;
        adr_src    = 1'b0;
        mem_write  = 1'b0;
        ir_write   = 1'b0;
        result_src = 2'b00;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        reg_write  = 1'b0;
        alu_op     = ALU_OP_ADD;
        illegal_op = 1'b0;
        case (state_q)
            StFetch: begin
                ir_write   = 1'b1;
                pc_write   = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            StDecode: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b01;
                illegal_op = !op_legal;
            end
            StMemAdr: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            StMemRead: adr_src = 1'b1;
            StMemWb: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
            end
            StMemWrite: begin
                adr_src   = 1'b1;
                mem_write = 1'b1;
            end
            StExecR: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_OP_FUNCT;
            end
            StExecI: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALU_OP_FUNCT;
            end
            StAluWb: reg_write = 1'b1;
            StJal: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b10;
                pc_write  = 1'b1;
            end
            StBeq: begin
                alu_src_a = 2'b10;
                alu_op    = ALU_OP_SUB;
                pc_write  = zero;
            end
            default: ;
        endcase
        ALUControl = alu_ctl;
        // Gate everything while reset is held so an aborted instruction stops writing at once.
        if (!reset_n) begin
            pc_write   = 1'b0;
            adr_src    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            result_src = 2'b00;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            reg_write  = 1'b0;
            ALUControl = 3'b000;
            illegal_op = 1'b0;
        end
    end

    // Immediate format follows the instruction so decode builds the right branch/jump target.
    always_comb begin
        imm_src = 2'b00;
        if (reset_n) begin
            case (op)
                OP_SW:   imm_src = 2'b01;
                OP_BEQ:  imm_src = 2'b10;
                OP_JAL:  imm_src = 2'b11;
                default: imm_src = 2'b00;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench: per-instruction phase model of the control unit.
module tb_multicycle_control_fsm;

    typedef struct packed {
        logic       pc_write;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] imm_src;
        logic       reg_write;
        logic [2:0] alu_ctl;
        logic       illegal;
    } ctrl_t;

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [6:0] op = RT;
    logic [2:0] funct3 = 3'b000;
    logic       funct7b5 = 1'b0;
    logic       zero = 1'b0;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_op;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [2:0] alu_control;
    ctrl_t      got;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control_fsm #(.TRACE(1'b0)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .zero       (zero),
        .pc_write   (pc_write),
        .adr_src    (adr_src),
        .mem_write  (mem_write),
        .ir_write   (ir_write),
        .result_src (result_src),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .imm_src    (imm_src),
        .reg_write  (reg_write),
        .ALUControl (alu_control),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    assign got = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a, alu_src_b,
                  imm_src, reg_write, alu_control, illegal_op};

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_legal(input logic [6:0] o);
        return o == LW || o == SW || o == RT || o == IT || o == BQ || o == JL;
    endfunction

    // Phase sequence of each instruction class, as named in the instruction timing.
    function automatic int n_phases(input logic [6:0] o);
        case (o)
            LW:      return 5;
            SW, RT, IT, JL: return 4;
            BQ:      return 3;
            default: return 2;
        endcase
    endfunction

    function automatic string phase_at(input logic [6:0] o, input int k);
        if (k == 0) return "fetch";
        if (k == 1) return "decode";
        case (o)
            LW:      return (k == 2) ? "memadr" : (k == 3) ? "memread" : "memwb";
            SW:      return (k == 2) ? "memadr" : "memwrite";
            RT:      return (k == 2) ? "execr" : "aluwb";
            IT:      return (k == 2) ? "execi" : "aluwb";
            JL:      return (k == 2) ? "jal" : "aluwb";
            default: return "beq";
        endcase
    endfunction

    function automatic logic [2:0] alu_func(input bit is_r, input logic [2:0] f3, input logic f7);
        case (f3)
            3'b000:  return (is_r && f7) ? 3'b001 : 3'b000;
            3'b010:  return 3'b101;
            3'b110:  return 3'b110;
            3'b111:  return 3'b010;
            default: return 3'b000;
        endcase
    endfunction

    function automatic ctrl_t model(input string ph, input logic [6:0] o, input logic [2:0] f3,
                                    input logic f7, input logic z);
        ctrl_t c = '0;
        c.imm_src = (o == SW) ? 2'b01 : (o == BQ) ? 2'b10 : (o == JL) ? 2'b11 : 2'b00;
        case (ph)
            "fetch": begin
                c.ir_write = 1; c.pc_write = 1; c.alu_src_b = 2'b10; c.result_src = 2'b10;
            end
            "decode": begin
                c.alu_src_a = 2'b01; c.alu_src_b = 2'b01; c.illegal = !is_legal(o);
            end
            "memadr":   begin c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; end
            "memread":  c.adr_src = 1;
            "memwb":    begin c.result_src = 2'b01; c.reg_write = 1; end
            "memwrite": begin c.adr_src = 1; c.mem_write = 1; end
            "execr":    begin c.alu_src_a = 2'b10; c.alu_ctl = alu_func(1, f3, f7); end
            "execi": begin
                c.alu_src_a = 2'b10; c.alu_src_b = 2'b01; c.alu_ctl = alu_func(0, f3, f7);
            end
            "aluwb":    c.reg_write = 1;
            "jal":      begin c.alu_src_a = 2'b01; c.alu_src_b = 2'b10; c.pc_write = 1; end
            "beq":      begin c.alu_src_a = 2'b10; c.alu_ctl = 3'b001; c.pc_write = z; end
            default: ;
        endcase
        return c;
    endfunction

    // zmode: 0/1 hold zero fixed, 2 randomize it every cycle.
    task automatic run_instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                             input int zmode, input bit abort_last);
        int n = n_phases(o);
        for (int k = 0; k < n; k++) begin
            string ph = phase_at(o, k);
            @(negedge clk);
            if (k == 0) begin
                op = o; funct3 = f3; funct7b5 = f7;
            end
            zero = (zmode == 2) ? 1'($urandom) : 1'(zmode);
            #1;
            check_eq(ph, 32'(got), 32'(model(ph, o, f3, f7, zero)));
            if (abort_last && k == n - 1) begin
                #1 reset_n = 1'b0;
                #1 check_eq("abort_async", 32'(got), 32'd0);
                repeat (2) begin
                    @(negedge clk);
                    check_eq("abort_hold", 32'(got), 32'd0);
                end
                @(posedge clk);
                #2 reset_n = 1'b1;
            end
        end
    endtask

    initial begin
        logic [6:0] rop;
        int sel;
        repeat (3) begin
            @(negedge clk);
            check_eq("reset_outputs", 32'(got), 32'd0);
        end
        @(posedge clk);
        #2 reset_n = 1'b1;

        run_instr(RT, 3'b000, 1'b1, 2, 1'b0);
        run_instr(LW, 3'b010, 1'b0, 2, 1'b0);
        run_instr(RT, 3'b000, 1'b0, 2, 1'b0);
        run_instr(IT, 3'b000, 1'b1, 2, 1'b0);
        run_instr(BQ, 3'b000, 1'b0, 1, 1'b0);
        run_instr(BQ, 3'b000, 1'b0, 0, 1'b0);
        run_instr(7'b0000000, 3'b000, 1'b0, 2, 1'b0);
        run_instr(JL, 3'b000, 1'b0, 2, 1'b0);
        run_instr(SW, 3'b010, 1'b0, 2, 1'b1);
        run_instr(LW, 3'b010, 1'b0, 2, 1'b0);

        for (int i = 0; i < 300; i++) begin
            sel = int'($urandom_range(0, 6));
            case (sel)
                0: rop = LW;
                1: rop = SW;
                2: rop = RT;
                3: rop = IT;
                4: rop = BQ;
                5: rop = JL;
                default: begin
                    rop = 7'($urandom);
                    while (is_legal(rop)) rop = 7'($urandom);
                end
            endcase
            run_instr(rop, 3'($urandom), 1'($urandom), 2, ($urandom_range(0, 19) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
